ad9958_spi_responder: RTL and testbench



---
 rtl/ad9958_spi_responder.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ad9958_spi_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad9958_spi_responder.sv
// AD9958 serial control port responder: samples the SPI lines in the clock domain,
// decodes instruction/data phases into register buffers and commits them on io_update.
module ad9958_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sclk,
    input  logic        cs_n,
    input  logic [3:0]  sdio,
    input  logic        io_update,
    input  logic        master_reset,
    output logic [7:0]  csr,
    output logic [23:0] fr1,
    output logic [15:0] fr2,
    output logic [23:0] cfr_ch0,
    output logic [23:0] cfr_ch1,
    output logic [31:0] ftw_ch0,
    output logic [31:0] ftw_ch1,
    output logic [15:0] pow_ch0,
    output logic [15:0] pow_ch1,
    output logic [23:0] acr_ch0,
    output logic [23:0] acr_ch1,
    output logic        update_strobe,
    output logic        write_strobe,
    output logic [4:0]  last_addr,
    output logic        frame_error
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_INSTR   = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_COMMIT  = 3'd3;
    localparam logic [2:0] ST_DISCARD = 3'd4;

    // Packed serial-side inputs: {master_reset, io_update, cs_n, sclk, sdio[3:0]}; cs_n idles high.
    localparam logic [7:0]  SYNC_RST = 8'h20;
    localparam logic [23:0] CFR_DEF  = 24'h000302;

    logic [7:0] sync_q [SYNC_STAGES];
    logic [7:0] sync_s, prev_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
            prev_q <= SYNC_RST;
        end else begin
            sync_q[0] <= {master_reset, io_update, cs_n, sclk, sdio};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_s;
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    logic       mr_s, cs_low, sclk_rise, cs_rise, iou_rise;
    logic [3:0] sdio_s;
    assign mr_s      = sync_s[7];
    assign cs_low    = ~sync_s[5];
    assign sdio_s    = sync_s[3:0];
    assign sclk_rise = sync_s[4] & ~prev_q[4];
    assign cs_rise   = sync_s[5] & ~prev_q[5];
    assign iou_rise  = sync_s[6] & ~prev_q[6];

    function automatic logic [5:0] reg_bits(input logic [4:0] addr);
        case (addr)
            5'd1, 5'd3, 5'd6: reg_bits = 6'd24;
            5'd2, 5'd5:       reg_bits = 6'd16;
            5'd4:             reg_bits = 6'd32;
            default:          reg_bits = 6'd8;
        endcase
    endfunction

    logic [2:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d, len_q, len_d, step, cnt_next;
    logic [31:0] sh_q, sh_d, sh_next, word, data_q, data_d;
    logic [1:0]  mode_q, mode_d;
    logic [4:0]  addr_q, addr_d, last_addr_q, last_addr_d;
    logic        eff_wide, eff_lsb, commit, frame_d, wstb_q, ferr_q;
    logic [7:0]  csr_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sh_d    = sh_q;
        mode_d  = mode_q;
        addr_d  = addr_q;
        data_d  = data_q;
        frame_d = 1'b0;
        commit  = 1'b0;
        // The first instruction bit uses the live csr so a csr write earlier in the same frame applies.
        eff_wide = (state_q == ST_INSTR && cnt_q == 6'd0) ? (csr_q[2:1] == 2'b11) : mode_q[1];
        eff_lsb  = (state_q == ST_INSTR && cnt_q == 6'd0) ? csr_q[0] : mode_q[0];
        step     = eff_wide ? 6'd4 : 6'd1;
        cnt_next = cnt_q + step;
        if (eff_lsb) sh_next = eff_wide ? {sdio_s, sh_q[31:4]} : {sdio_s[0], sh_q[31:1]};
        else         sh_next = eff_wide ? {sh_q[27:0], sdio_s} : {sh_q[30:0], sdio_s[0]};
        word = eff_lsb ? (sh_next >> (6'd32 - len_q)) : sh_next;

        case (state_q)
            ST_IDLE: if (cs_low) begin
                state_d = ST_INSTR;
                cnt_d   = 6'd0;
                len_d   = 6'd8;
                sh_d    = '0;
            end
            ST_INSTR, ST_DATA: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    frame_d = !(state_q == ST_INSTR && cnt_q == 6'd0);
                end else if (sclk_rise) begin
                    sh_d  = sh_next;
                    cnt_d = cnt_next;
                    if (state_q == ST_INSTR && cnt_q == 6'd0) mode_d = {eff_wide, eff_lsb};
                    if (cnt_next >= len_q) begin
                        if (state_q == ST_DATA) begin
                            data_d  = word;
                            state_d = ST_COMMIT;
                        end else if (word[7] || word[4:0] > 5'd6) begin
                            state_d = ST_DISCARD;
                            frame_d = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                            addr_d  = word[4:0];
                            len_d   = reg_bits(word[4:0]);
                            cnt_d   = 6'd0;
                            sh_d    = '0;
                        end
                    end
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                state_d = cs_low ? ST_INSTR : ST_IDLE;
                cnt_d   = 6'd0;
                len_d   = 6'd8;
                sh_d    = '0;
            end
            ST_DISCARD: if (!cs_low) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        last_addr_d = commit ? addr_q : last_addr_q;
    end

    logic [23:0] fr1_buf_q, fr1_buf_d, fr1_act_q, fr1_act_d;
    logic [15:0] fr2_buf_q, fr2_buf_d, fr2_act_q, fr2_act_d;
    logic [23:0] cfr_buf_q [2], cfr_buf_d [2], cfr_act_q [2], cfr_act_d [2];
    logic [31:0] ftw_buf_q [2], ftw_buf_d [2], ftw_act_q [2], ftw_act_d [2];
    logic [15:0] pow_buf_q [2], pow_buf_d [2], pow_act_q [2], pow_act_d [2];
    logic [23:0] acr_buf_q [2], acr_buf_d [2], acr_act_q [2], acr_act_d [2];
    logic [7:0]  csr_d;
    logic        upd_q, upd_d;

    always_comb begin
        csr_d     = csr_q;
        fr1_buf_d = fr1_buf_q;  fr1_act_d = fr1_act_q;
        fr2_buf_d = fr2_buf_q;  fr2_act_d = fr2_act_q;
        cfr_buf_d = cfr_buf_q;  cfr_act_d = cfr_act_q;
        ftw_buf_d = ftw_buf_q;  ftw_act_d = ftw_act_q;
        pow_buf_d = pow_buf_q;  pow_act_d = pow_act_q;
        acr_buf_d = acr_buf_q;  acr_act_d = acr_act_q;
        upd_d     = 1'b0;
        if (commit) begin
            case (addr_q)
                5'd0: csr_d     = data_q[7:0];
                5'd1: fr1_buf_d = data_q[23:0];
                5'd2: fr2_buf_d = data_q[15:0];
                default: for (int ch = 0; ch < 2; ch++) begin
                    if (csr_q[6+ch]) begin
                        case (addr_q)
                            5'd3:    cfr_buf_d[ch] = data_q[23:0];
                            5'd4:    ftw_buf_d[ch] = data_q;
                            5'd5:    pow_buf_d[ch] = data_q[15:0];
                            5'd6:    acr_buf_d[ch] = data_q[23:0];
                            default: ;
                        endcase
                    end
                end
            endcase
        end
        // Copy from the next-state buffers so a same-cycle commit is visible at the outputs.
        if (iou_rise) begin
            fr1_act_d = fr1_buf_d;
            fr2_act_d = fr2_buf_d;
            cfr_act_d = cfr_buf_d;
            ftw_act_d = ftw_buf_d;
            pow_act_d = pow_buf_d;
            acr_act_d = acr_buf_d;
            upd_d     = 1'b1;
        end
    end

    // NOTE: the register file is small and must come up in known defaults, so every entry is reset.
    always_ff @(posedge clock) begin
        if (reset || mr_s) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            len_q       <= 6'd8;
            sh_q        <= '0;
            mode_q      <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            last_addr_q <= '0;
            wstb_q      <= 1'b0;
            ferr_q      <= 1'b0;
            upd_q       <= 1'b0;
            csr_q       <= 8'hF0;
            fr1_buf_q   <= '0;
            fr1_act_q   <= '0;
            fr2_buf_q   <= '0;
            fr2_act_q   <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                cfr_buf_q[ch] <= CFR_DEF;
                cfr_act_q[ch] <= CFR_DEF;
                ftw_buf_q[ch] <= '0;
                ftw_act_q[ch] <= '0;
                pow_buf_q[ch] <= '0;
                pow_act_q[ch] <= '0;
                acr_buf_q[ch] <= '0;
                acr_act_q[ch] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sh_q        <= sh_d;
            mode_q      <= mode_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            last_addr_q <= last_addr_d;
            wstb_q      <= commit;
            ferr_q      <= frame_d;
            upd_q       <= upd_d;
            csr_q       <= csr_d;
            fr1_buf_q   <= fr1_buf_d;
            fr1_act_q   <= fr1_act_d;
            fr2_buf_q   <= fr2_buf_d;
            fr2_act_q   <= fr2_act_d;
            cfr_buf_q   <= cfr_buf_d;
            cfr_act_q   <= cfr_act_d;
            ftw_buf_q   <= ftw_buf_d;
            ftw_act_q   <= ftw_act_d;
            pow_buf_q   <= pow_buf_d;
            pow_act_q   <= pow_act_d;
            acr_buf_q   <= acr_buf_d;
            acr_act_q   <= acr_act_d;
        end
    end

    assign csr           = csr_q;
    assign fr1           = fr1_act_q;
    assign fr2           = fr2_act_q;
    assign cfr_ch0       = cfr_act_q[0];
    assign cfr_ch1       = cfr_act_q[1];
    assign ftw_ch0       = ftw_act_q[0];
    assign ftw_ch1       = ftw_act_q[1];
    assign pow_ch0       = pow_act_q[0];
    assign pow_ch1       = pow_act_q[1];
    assign acr_ch0       = acr_act_q[0];
    assign acr_ch1       = acr_act_q[1];
    assign update_strobe = upd_q;
    assign write_strobe  = wstb_q;
    assign last_addr     = last_addr_q;
    assign frame_error   = ferr_q;
endmodule

// File: tb/tb_ad9958_spi_responder.sv
// Bench for ad9958_spi_responder: directed scenarios plus random writes checked
// against a register-level model of buffers, active outputs and the live csr.
module tb_ad9958_spi_responder;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sclk = 1'b0;
    logic        cs_n = 1'b1;
    logic [3:0]  sdio = 4'h0;
    logic        io_update = 1'b0;
    logic        master_reset = 1'b0;
    logic [7:0]  csr;
    logic [23:0] fr1, cfr_ch0, cfr_ch1, acr_ch0, acr_ch1;
    logic [15:0] fr2, pow_ch0, pow_ch1;
    logic [31:0] ftw_ch0, ftw_ch1;
    logic        update_strobe, write_strobe, frame_error;
    logic [4:0]  last_addr;

    ad9958_spi_responder #(.SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .sdio(sdio),
        .io_update(io_update), .master_reset(master_reset),
        .csr(csr), .fr1(fr1), .fr2(fr2), .cfr_ch0(cfr_ch0), .cfr_ch1(cfr_ch1),
        .ftw_ch0(ftw_ch0), .ftw_ch1(ftw_ch1), .pow_ch0(pow_ch0), .pow_ch1(pow_ch1),
        .acr_ch0(acr_ch0), .acr_ch1(acr_ch1), .update_strobe(update_strobe),
        .write_strobe(write_strobe), .last_addr(last_addr), .frame_error(frame_error)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0, fe_cnt = 0, up_cnt = 0;
    int w0, f0, u0;

    always @(negedge clock) begin
        if (write_strobe) wr_cnt++;
        if (frame_error)  fe_cnt++;
        if (update_strobe) up_cnt++;
    end

    // Model: register sizes, live csr, buffers and active copies (shared registers live in slot 0).
    int          m_bytes [7] = '{1, 3, 2, 3, 4, 2, 3};
    logic [7:0]  m_csr;
    logic [31:0] m_buf [2][7];
    logic [31:0] m_act [2][7];

    task automatic model_defaults();
        m_csr = 8'hF0;
        for (int ch = 0; ch < 2; ch++)
            for (int a = 0; a < 7; a++) begin
                m_buf[ch][a] = (a == 3) ? 32'h0000_0302 : 32'h0;
                m_act[ch][a] = m_buf[ch][a];
            end
    endtask

    task automatic model_write(input logic [4:0] addr, input logic [31:0] data);
        if (addr == 5'd0) m_csr = data[7:0];
        else if (addr <= 5'd2) m_buf[0][addr] = data;
        else for (int ch = 0; ch < 2; ch++) if (m_csr[6+ch]) m_buf[ch][addr] = data;
    endtask

    task automatic model_update();
        m_act = m_buf;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".csr"}, {24'h0, csr}, {24'h0, m_csr});
        check({tag, ".fr1"}, {8'h0, fr1}, m_act[0][1]);
        check({tag, ".fr2"}, {16'h0, fr2}, m_act[0][2]);
        check({tag, ".cfr0"}, {8'h0, cfr_ch0}, m_act[0][3]);
        check({tag, ".cfr1"}, {8'h0, cfr_ch1}, m_act[1][3]);
        check({tag, ".ftw0"}, ftw_ch0, m_act[0][4]);
        check({tag, ".ftw1"}, ftw_ch1, m_act[1][4]);
        check({tag, ".pow0"}, {16'h0, pow_ch0}, m_act[0][5]);
        check({tag, ".pow1"}, {16'h0, pow_ch1}, m_act[1][5]);
        check({tag, ".acr0"}, {8'h0, acr_ch0}, m_act[0][6]);
        check({tag, ".acr1"}, {8'h0, acr_ch1}, m_act[1][6]);
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clock);
    endtask

    function automatic logic serial_bit(input logic [31:0] val, input int len, input int j, input logic lsb);
        return lsb ? val[j] : val[len-1-j];
    endfunction

    // Sends the first `count` serial bits of a `len`-bit word in the mode the model csr selects.
    task automatic send_bits(input logic [31:0] val, input int len, input int count);
        logic       wide, lsb;
        logic [3:0] nib;
        int         i;
        wide = (m_csr[2:1] == 2'b11);
        lsb  = m_csr[0];
        i    = 0;
        while (i < count) begin
            nib = 4'h0;
            if (wide) begin
                for (int k = 0; k < 4; k++) begin
                    if (lsb) nib[k]   = serial_bit(val, len, i + k, lsb);
                    else     nib[3-k] = serial_bit(val, len, i + k, lsb);
                end
                i += 4;
            end else begin
                nib[0] = serial_bit(val, len, i, lsb);
                i++;
            end
            sdio = nib;
            clk_wait(6);
            sclk = 1'b1;
            clk_wait(6);
            sclk = 1'b0;
        end
    endtask

    function automatic logic [31:0] masked(input logic [31:0] data, input int nb);
        return (nb >= 32) ? data : (data & ((32'd1 << nb) - 32'd1));
    endfunction

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        int          nb;
        logic [31:0] d;
        nb = m_bytes[addr] * 8;
        d  = masked(data, nb);
        send_bits({27'h0, addr}, 8, 8);
        send_bits(d, nb, nb);
        model_write(addr, d);
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        clk_wait(6);
    endtask

    task automatic cs_end();
        clk_wait(6);
        cs_n = 1'b1;
        clk_wait(10);
    endtask

    task automatic io_pulse();
        io_update = 1'b1;
        clk_wait(6);
        io_update = 1'b0;
        clk_wait(8);
        model_update();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clk_wait(3);
        reset = 1'b0;
        clk_wait(2);
        model_defaults();
    endtask

    task automatic snap();
        w0 = wr_cnt;
        f0 = fe_cnt;
        u0 = up_cnt;
    endtask

    initial begin
        int n_wr;
        logic [4:0] a;
        model_defaults();
        do_reset();
        check_all("reset");
        check("reset.ws", {31'h0, write_strobe}, 32'h0);
        check("reset.fe", {31'h0, frame_error}, 32'h0);
        check("reset.us", {31'h0, update_strobe}, 32'h0);
        check("reset.last", {27'h0, last_addr}, 32'h0);

        // 2-wire MSB-first FTW write to both channels.
        snap();
        cs_begin();
        do_write(5'd4, 32'h1234_5678);
        cs_end();
        check("ftw.wr_cnt", wr_cnt - w0, 1);
        check("ftw.last", {27'h0, last_addr}, 32'd4);
        check_all("ftw.pre_io");
        io_pulse();
        check("ftw.up_cnt", up_cnt - u0, 1);
        check_all("ftw.post_io");

        // csr = 0x46 then 4-bit MSB-first ACR write within one frame.
        cs_begin();
        do_write(5'd0, 32'h46);
        do_write(5'd6, 32'h0013FF);
        cs_end();
        check("acr_msb.csr", {24'h0, csr}, 32'h46);
        io_pulse();
        check_all("acr_msb");
        check("acr_msb.acr0", {8'h0, acr_ch0}, 32'h0013FF);

        // Same with LSB-first: csr = 0x47.
        do_reset();
        snap();
        cs_begin();
        do_write(5'd0, 32'h47);
        do_write(5'd6, 32'h0013FF);
        cs_end();
        check("acr_lsb.wr_cnt", wr_cnt - w0, 2);
        io_pulse();
        check_all("acr_lsb");
        check("acr_lsb.acr0", {8'h0, acr_ch0}, 32'h0013FF);
        check("acr_lsb.acr1", {8'h0, acr_ch1}, 32'h0);

        // Partial FTW aborted by cs_n after 12 data bits.
        do_reset();
        cs_begin();
        do_write(5'd4, 32'hA5A5_A5A5);
        cs_end();
        io_pulse();
        snap();
        cs_begin();
        send_bits(32'h04, 8, 8);
        send_bits(32'h0BAD_F00D, 32, 12);
        cs_end();
        check("abort.fe_cnt", fe_cnt - f0, 1);
        check("abort.wr_cnt", wr_cnt - w0, 0);
        io_pulse();
        check_all("abort");

        // Read instruction is rejected; the rest of the frame is ignored.
        snap();
        cs_begin();
        send_bits(32'h84, 8, 8);
        send_bits(32'h5A, 8, 8);
        cs_end();
        check("read.fe_cnt", fe_cnt - f0, 1);
        check("read.wr_cnt", wr_cnt - w0, 0);
        check_all("read");

        // Random writes, random csr modes/channel enables, random commits.
        for (int it = 0; it < 24; it++) begin
            snap();
            n_wr = $urandom_range(1, 2);
            cs_begin();
            for (int k = 0; k < n_wr; k++) begin
                a = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 6));
                do_write(a, $urandom);
            end
            cs_end();
            check("rand.wr_cnt", wr_cnt - w0, n_wr);
            check("rand.fe_cnt", fe_cnt - f0, 0);
            check("rand.last", {27'h0, last_addr}, {27'h0, a});
            if ($urandom_range(0, 2) == 0) begin
                io_pulse();
                check("rand.up_cnt", up_cnt - u0, 1);
                check_all("rand");
            end else begin
                check("rand.csr", {24'h0, csr}, {24'h0, m_csr});
            end
        end
        io_pulse();
        check_all("rand.final");

        // FTW write without io_update, then master_reset mid-transfer.
        cs_begin();
        do_write(5'd4, 32'hCAFE_0001);
        cs_end();
        check_all("noio");
        cs_begin();
        send_bits(32'h03, 8, 8);
        send_bits(32'h00FF_FF, 24, 10);
        master_reset = 1'b1;
        clk_wait(10);
        master_reset = 1'b0;
        clk_wait(6);
        cs_n = 1'b1;
        clk_wait(10);
        model_defaults();
        check("mreset.csr", {24'h0, csr}, 32'hF0);
        check("mreset.cfr0", {8'h0, cfr_ch0}, 32'h000302);
        check_all("mreset");
        snap();
        io_pulse();
        check("mreset.up_cnt", up_cnt - u0, 1);
        check_all("mreset.io");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
